// File: rtl/alu_ir_regfile_datapath_pkg.sv
// ---------------------------------------------------------------------------
// alu_ir_regfile_datapath_pkg
// Shared encodings for the 8-bit datapath core.
// It holds the register/IR function selects, the ALU opcodes and the flag
// bit positions inside alu_flags ({Z,C,N,O}). It also holds the signed
// overflow helpers used by the ALU.
// ---------------------------------------------------------------------------
package alu_ir_regfile_datapath_pkg;

  typedef logic [1:0] funsel_t;

  // Register / IR function selects
  localparam funsel_t FS_CLR = 2'b00;
  localparam funsel_t FS_LD  = 2'b01;
  localparam funsel_t FS_DEC = 2'b10;
  localparam funsel_t FS_INC = 2'b11;

  // ALU opcodes
  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b0001;
  localparam logic [3:0] ALU_NOT_A  = 4'b0010;
  localparam logic [3:0] ALU_NOT_B  = 4'b0011;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0101;
  localparam logic [3:0] ALU_CMP    = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;
  localparam logic [3:0] ALU_NAND   = 4'b1001;
  localparam logic [3:0] ALU_XOR    = 4'b1010;
  localparam logic [3:0] ALU_LSL    = 4'b1011;
  localparam logic [3:0] ALU_LSR    = 4'b1100;
  localparam logic [3:0] ALU_ASL    = 4'b1101;
  localparam logic [3:0] ALU_ASR    = 4'b1110;
  localparam logic [3:0] ALU_CSR    = 4'b1111;

  // Flag bit positions in alu_flags = {Z,C,N,O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  // Signed overflow of a+b: operands agree in sign, result disagrees.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a-b: operands differ in sign, result sign differs from a.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_ir_regfile_datapath_reg_cell.sv
// ---------------------------------------------------------------------------
// alu_ir_regfile_datapath_reg_cell
// W-bit register with an enable and a 2-bit function select. The function
// select chooses clear, load, decrement or increment. Decrement and
// increment wrap modulo 2^W. When the enable is low the register holds.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears to 0)
//   en         : perform funsel on this edge
//   funsel     : FS_CLR / FS_LD / FS_DEC / FS_INC
//   load       : value taken on FS_LD
//   q          : register contents
// ---------------------------------------------------------------------------
module alu_ir_regfile_datapath_reg_cell
  import alu_ir_regfile_datapath_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  funsel_t      funsel,
  input  logic [W-1:0] load,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next-state selection for the enabled function.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (funsel)
        FS_CLR:  q_d = {W{1'b0}};
        FS_LD:   q_d = load;
        FS_DEC:  q_d = q_q - {{(W-1){1'b0}}, 1'b1};
        FS_INC:  q_d = q_q + {{(W-1){1'b0}}, 1'b1};
        default: q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= {W{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/alu_ir_regfile_datapath.sv
// ---------------------------------------------------------------------------
// alu_ir_regfile_datapath
// 8-bit datapath core with an 8-entry register file (T1-T4, R1-R4) and a
// 16-bit instruction register. It also contains an ALU whose {Z,C,N,O}
// flags are latched on every clock edge.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   rf_load/funsel/rsel/tsel    : file write data, op, R and T enables (bit3 = R1/T1)
//   rf_o1sel/rf_o2sel           : read selects (000-011 T1-T4, 100-111 R1-R4)
//   rf_o1/rf_o2                 : combinational read data, also ALU A/B
//   ir_data/enable/funsel/lh    : IR byte input, enable, op, half select
//   ir_out                      : IR contents
//   alu_funsel/alu_out          : ALU opcode and combinational result
//   alu_flags                   : registered {Z,C,N,O}
// ---------------------------------------------------------------------------
module alu_ir_regfile_datapath
  import alu_ir_regfile_datapath_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   rf_load,
  input  logic [1:0]     rf_funsel,
  input  logic [3:0]     rf_rsel,
  input  logic [3:0]     rf_tsel,
  input  logic [2:0]     rf_o1sel,
  input  logic [2:0]     rf_o2sel,
  output logic [N-1:0]   rf_o1,
  output logic [N-1:0]   rf_o2,
  input  logic [N-1:0]   ir_data,
  input  logic           ir_enable,
  input  logic [1:0]     ir_funsel,
  input  logic           ir_lh,
  output logic [2*N-1:0] ir_out,
  input  logic [3:0]     alu_funsel,
  output logic [N-1:0]   alu_out,
  output logic [3:0]     alu_flags
);

  // Entry index equals the read-select code: 0-3 = T1-T4, 4-7 = R1-R4.
  logic [7:0][N-1:0] rf_q;
  // {tsel, rsel} puts T1 at bit 7 and R4 at bit 0, so entry i uses bit 7-i.
  logic [7:0]        rf_en;

  assign rf_en = {rf_tsel, rf_rsel};

  for (genvar gi = 0; gi < 8; gi++) begin : g_rf
    alu_ir_regfile_datapath_reg_cell #(.W(N)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (rf_en[7-gi]),
      .funsel (rf_funsel),
      .load   (rf_load),
      .q      (rf_q[gi])
    );
  end

  function automatic logic [N-1:0] rd_mux(input logic [2:0] sel,
                                          input logic [7:0][N-1:0] regs);
    case (sel)
      3'b000:  return regs[0];
      3'b001:  return regs[1];
      3'b010:  return regs[2];
      3'b011:  return regs[3];
      3'b100:  return regs[4];
      3'b101:  return regs[5];
      3'b110:  return regs[6];
      3'b111:  return regs[7];
      default: return regs[0];
    endcase
  endfunction

  assign rf_o1 = rd_mux(rf_o1sel, rf_q);
  assign rf_o2 = rd_mux(rf_o2sel, rf_q);

  // The IR is a single 2N-bit cell so inc/dec carry across both halves.
  // A load rewrites only one half and feeds the other half back unchanged.
  logic [2*N-1:0] ir_load;

  // Build the IR load word from the selected half.
  always_comb begin
    if (ir_lh) begin
      ir_load = {ir_data, ir_out[N-1:0]};
    end else begin
      ir_load = {ir_out[2*N-1:N], ir_data};
    end
  end

  alu_ir_regfile_datapath_reg_cell #(.W(2*N)) u_ir (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ir_enable),
    .funsel (ir_funsel),
    .load   (ir_load),
    .q      (ir_out)
  );

  // ALU
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N:0]   sum_w;
  logic [N:0]   diff_w;
  logic [N-1:0] res;
  logic [N-1:0] zn_src;
  logic         c_next;
  logic         o_next;
  logic [3:0]   flags_d;
  logic [3:0]   flags_q;

  assign a      = rf_o1;
  assign b      = rf_o2;
  assign sum_w  = {1'b0, a} + {1'b0, b};
  // The top bit of the difference is the borrow, set when A < B unsigned.
  assign diff_w = {1'b0, a} - {1'b0, b};

  // Result and C/O update. Ops that do not define C or O leave them held.
  always_comb begin
    res    = a;
    c_next = flags_q[FLAG_C];
    o_next = flags_q[FLAG_O];
    case (alu_funsel)
      ALU_PASS_A: res = a;
      ALU_PASS_B: res = b;
      ALU_NOT_A:  res = ~a;
      ALU_NOT_B:  res = ~b;
      ALU_ADD: begin
        res    = sum_w[N-1:0];
        c_next = sum_w[N];
        o_next = add_overflow(a[N-1], b[N-1], sum_w[N-1]);
      end
      ALU_SUB: begin
        res    = diff_w[N-1:0];
        c_next = diff_w[N];
        o_next = sub_overflow(a[N-1], b[N-1], diff_w[N-1]);
      end
      ALU_CMP: begin
        res    = a;
        c_next = diff_w[N];
        o_next = sub_overflow(a[N-1], b[N-1], diff_w[N-1]);
      end
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_NAND: res = ~(a & b);
      ALU_XOR:  res = a ^ b;
      ALU_LSL: begin
        res    = {a[N-2:0], 1'b0};
        c_next = a[N-1];
      end
      ALU_LSR: begin
        res    = {1'b0, a[N-1:1]};
        c_next = a[0];
      end
      ALU_ASL: begin
        res    = {a[N-2:0], 1'b0};
        c_next = a[N-1];
        o_next = a[N-1] ^ a[N-2];
      end
      ALU_ASR: begin
        res    = {a[N-1], a[N-1:1]};
        c_next = a[0];
      end
      ALU_CSR: begin
        res    = {a[0], a[N-1:1]};
        c_next = a[0];
      end
      default: res = a;
    endcase
  end

  // CMP outputs A, but its Z and N come from the difference.
  assign zn_src = (alu_funsel == ALU_CMP) ? diff_w[N-1:0] : res;

  // Assemble the next flag word.
  always_comb begin
    flags_d         = flags_q;
    flags_d[FLAG_Z] = (zn_src == {N{1'b0}});
    flags_d[FLAG_C] = c_next;
    flags_d[FLAG_N] = zn_src[N-1];
    flags_d[FLAG_O] = o_next;
  end

  // Flag register, updated every edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign alu_out   = res;
  assign alu_flags = flags_q;

endmodule

// File: tb/tb_alu_ir_regfile_datapath.sv
// Self-checking bench: reference model of file/IR/ALU plus hand-derived
// ALU vectors, directed file/IR sequences and randomized cycles.
module tb_alu_ir_regfile_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rf_load;
  logic [1:0]  rf_funsel;
  logic [3:0]  rf_rsel;
  logic [3:0]  rf_tsel;
  logic [2:0]  rf_o1sel;
  logic [2:0]  rf_o2sel;
  logic [7:0]  rf_o1;
  logic [7:0]  rf_o2;
  logic [7:0]  ir_data;
  logic        ir_enable;
  logic [1:0]  ir_funsel;
  logic        ir_lh;
  logic [15:0] ir_out;
  logic [3:0]  alu_funsel;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;

  always #5 clk = ~clk;

  alu_ir_regfile_datapath #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rf_load(rf_load), .rf_funsel(rf_funsel), .rf_rsel(rf_rsel), .rf_tsel(rf_tsel),
    .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel), .rf_o1(rf_o1), .rf_o2(rf_o2),
    .ir_data(ir_data), .ir_enable(ir_enable), .ir_funsel(ir_funsel), .ir_lh(ir_lh),
    .ir_out(ir_out), .alu_funsel(alu_funsel), .alu_out(alu_out), .alu_flags(alu_flags)
  );

  int checks = 0;
  int errors = 0;

  // Model state: entry index = read-select code (0-3 T1-T4, 4-7 R1-R4)
  logic [7:0]  m_rf [0:7];
  logic [15:0] m_ir;
  logic [3:0]  m_flags;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic [3:0] fl;
    logic [3:0] mask;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ALU behaviour from plain integer arithmetic; flags {Z,C,N,O}
  task automatic alu_ref(input logic [3:0] op, input int a, input int b,
                         input logic [3:0] fin, output int res, output logic [3:0] fout);
    int sa, sb, s, zn;
    logic z, c, n, o;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = fin[2];
    o = fin[0];
    case (op)
      4'd0:  res = a;
      4'd1:  res = b;
      4'd2:  res = 255 - a;
      4'd3:  res = 255 - b;
      4'd4: begin
        s = a + b; res = s % 256; c = (s > 255);
        o = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      4'd5, 4'd6: begin
        s = a - b; res = (s + 256) % 256; c = (a < b);
        o = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      4'd7:  res = a & b;
      4'd8:  res = a | b;
      4'd9:  res = 255 - (a & b);
      4'd10: res = a ^ b;
      4'd11: begin res = (a * 2) % 256; c = (a >= 128); end
      4'd12: begin res = a / 2; c = (a % 2 == 1); end
      4'd13: begin
        res = (a * 2) % 256; c = (a >= 128);
        o = ((a >= 128) != (res >= 128));
      end
      4'd14: begin res = a / 2 + ((a >= 128) ? 128 : 0); c = (a % 2 == 1); end
      4'd15: begin res = a / 2 + (a % 2) * 128; c = (a % 2 == 1); end
      default: res = a;
    endcase
    zn = res;
    if (op == 4'd6) res = a;
    z = (zn == 0);
    n = (zn >= 128);
    fout = {z, c, n, o};
  endtask

  // Advance the model by one clock edge using the current inputs
  task automatic model_edge();
    int res, v;
    logic [3:0] fl;
    logic en;
    alu_ref(alu_funsel, int'(m_rf[rf_o1sel]), int'(m_rf[rf_o2sel]), m_flags, res, fl);
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      m_ir = 16'h0000;
      m_flags = 4'b0000;
    end else begin
      m_flags = fl;
      for (int i = 0; i < 8; i++) begin
        if (i < 4) en = rf_tsel[3 - i];
        else       en = rf_rsel[7 - i];
        if (en) begin
          v = int'(m_rf[i]);
          case (rf_funsel)
            2'd0: v = 0;
            2'd1: v = int'(rf_load);
            2'd2: v = (v + 255) % 256;
            default: v = (v + 1) % 256;
          endcase
          m_rf[i] = v[7:0];
        end
      end
      if (ir_enable) begin
        v = int'(m_ir);
        case (ir_funsel)
          2'd0: v = 0;
          2'd1: v = ir_lh ? (int'(ir_data) * 256 + v % 256) : ((v / 256) * 256 + int'(ir_data));
          2'd2: v = (v + 65535) % 65536;
          default: v = (v + 1) % 65536;
        endcase
        m_ir = v[15:0];
      end
    end
  endtask

  task automatic check_outputs();
    int res;
    logic [3:0] fl;
    alu_ref(alu_funsel, int'(m_rf[rf_o1sel]), int'(m_rf[rf_o2sel]), m_flags, res, fl);
    check("model_rf_o1", rf_o1, m_rf[rf_o1sel]);
    check("model_rf_o2", rf_o2, m_rf[rf_o2sel]);
    check("model_alu_out", alu_out, res[7:0]);
    check("model_flags", alu_flags, m_flags);
    check("model_ir", ir_out, m_ir);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    rf_rsel = 4'b0000;
    rf_tsel = 4'b0000;
    ir_enable = 1'b0;
  endtask

  task automatic set_ab(input logic [7:0] a, input logic [7:0] b);
    rf_tsel = 4'b0000;
    rf_funsel = 2'b01;
    rf_rsel = 4'b1000; rf_load = a; step();
    rf_rsel = 4'b0100; rf_load = b; step();
    rf_rsel = 4'b0000;
    rf_o1sel = 3'b100;
    rf_o2sel = 3'b101;
  endtask

  initial begin
    vecs[0]  = '{4'b0100, 8'h7F, 8'h00, 8'h7F, 4'b0000, 4'b1111};
    vecs[1]  = '{4'b1011, 8'h7F, 8'h00, 8'hFE, 4'b0010, 4'b1110};
    vecs[2]  = '{4'b1111, 8'h7F, 8'h00, 8'hBF, 4'b0110, 4'b1110};
    vecs[3]  = '{4'b0101, 8'hAA, 8'hAA, 8'h00, 4'b1000, 4'b1111};
    vecs[4]  = '{4'b0110, 8'hAA, 8'hAA, 8'hAA, 4'b1000, 4'b1111};
    vecs[5]  = '{4'b1010, 8'hAA, 8'hAA, 8'h00, 4'b1000, 4'b1010};
    vecs[6]  = '{4'b0100, 8'hFF, 8'h7F, 8'h7E, 4'b0100, 4'b1111};
    vecs[7]  = '{4'b0100, 8'h7F, 8'h7F, 8'hFE, 4'b0011, 4'b1111};
    vecs[8]  = '{4'b1110, 8'hFF, 8'h00, 8'hFF, 4'b0110, 4'b1110};
    vecs[9]  = '{4'b0101, 8'h80, 8'h01, 8'h7F, 4'b0001, 4'b1111};
    vecs[10] = '{4'b0101, 8'h01, 8'h02, 8'hFF, 4'b0110, 4'b1111};
    vecs[11] = '{4'b1101, 8'hC0, 8'h00, 8'h80, 4'b0110, 4'b1111};
    vecs[12] = '{4'b1101, 8'h40, 8'h00, 8'h80, 4'b0011, 4'b1111};
    vecs[13] = '{4'b1001, 8'hF0, 8'h0F, 8'hFF, 4'b0010, 4'b1010};
    vecs[14] = '{4'b0010, 8'h55, 8'h00, 8'hAA, 4'b0010, 4'b1010};
    vecs[15] = '{4'b0001, 8'h12, 8'h34, 8'h34, 4'b0000, 4'b1010};
    vecs[16] = '{4'b1100, 8'h81, 8'h00, 8'h40, 4'b0100, 4'b1110};
    vecs[17] = '{4'b0111, 8'hF0, 8'h0F, 8'h00, 4'b1000, 4'b1010};
    vecs[18] = '{4'b0000, 8'h80, 8'h00, 8'h80, 4'b0010, 4'b1010};
    vecs[19] = '{4'b0011, 8'h00, 8'hFF, 8'h00, 4'b1000, 4'b1010};

    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_ir = 16'h0000;
    m_flags = 4'b0000;
    rst_n = 1'b0;
    rf_load = 8'h00; rf_funsel = 2'b00; rf_rsel = 4'b0000; rf_tsel = 4'b0000;
    rf_o1sel = 3'b000; rf_o2sel = 3'b000;
    ir_data = 8'h00; ir_enable = 1'b0; ir_funsel = 2'b00; ir_lh = 1'b0;
    alu_funsel = 4'b0000;
    step();
    step();
    check("reset_ir", ir_out, 16'h0000);
    check("reset_flags", alu_flags, 4'b0000);
    check("reset_rf", rf_o1, 8'h00);
    rst_n = 1'b1;

    // Register file load / read / increment
    rf_rsel = 4'b0100; rf_tsel = 4'b0001; rf_funsel = 2'b01; rf_load = 8'h95;
    rf_o1sel = 3'b101; rf_o2sel = 3'b011;
    #1;
    check("rf_old_value_before_edge", rf_o1, 8'h00);
    step();
    check("rf_load_r2", rf_o1, 8'h95);
    check("rf_load_t4", rf_o2, 8'h95);
    rf_funsel = 2'b11;
    repeat (3) step();
    check("rf_inc3_r2", rf_o1, 8'h98);
    check("rf_inc3_t4", rf_o2, 8'h98);
    idle();
    for (int s = 0; s < 8; s++) begin
      if (s != 5 && s != 3) begin
        rf_o1sel = 3'(s);
        step();
        check("rf_unselected_zero", rf_o1, 8'h00);
      end
    end
    rf_rsel = 4'b1000; rf_funsel = 2'b10; rf_o1sel = 3'b100;
    step();
    check("rf_dec_wrap", rf_o1, 8'hFF);
    idle();

    // IR sequence
    ir_enable = 1'b1; ir_lh = 1'b1; ir_funsel = 2'b01; ir_data = 8'h95;
    step(); check("ir_load_high", ir_out, 16'h9500);
    ir_lh = 1'b0; ir_data = 8'h01;
    step(); check("ir_load_low", ir_out, 16'h9501);
    ir_funsel = 2'b11;
    repeat (2) step();
    check("ir_inc2", ir_out, 16'h9503);
    ir_funsel = 2'b00;
    step(); check("ir_clear", ir_out, 16'h0000);
    ir_funsel = 2'b10;
    step(); check("ir_dec_wrap", ir_out, 16'hFFFF);
    ir_funsel = 2'b11;
    step(); check("ir_inc_wrap", ir_out, 16'h0000);
    ir_enable = 1'b0;
    step(); check("ir_hold", ir_out, 16'h0000);

    // ALU vector table
    for (int i = 0; i < 20; i++) begin
      set_ab(vecs[i].a, vecs[i].b);
      alu_funsel = vecs[i].op;
      #1;
      check("alu_vec_out", alu_out, vecs[i].out);
      step();
      check("alu_vec_flags", alu_flags & vecs[i].mask, vecs[i].fl & vecs[i].mask);
    end

    // C/O held across a logic op
    set_ab(8'h7F, 8'h7F);
    alu_funsel = 4'b0100;
    step(); check("flags_add_ovf", alu_flags, 4'b0011);
    alu_funsel = 4'b0111;
    step(); check("flags_hold_co", alu_flags, 4'b0001);

    // Reset in the middle of incrementing
    rf_rsel = 4'b1111; rf_tsel = 4'b1111; rf_funsel = 2'b11;
    ir_enable = 1'b1; ir_funsel = 2'b11;
    alu_funsel = 4'b0100;
    repeat (2) step();
    rst_n = 1'b0;
    rf_o1sel = 3'b100; rf_o2sel = 3'b000;
    step();
    check("rst_mid_r1", rf_o1, 8'h00);
    check("rst_mid_t1", rf_o2, 8'h00);
    check("rst_mid_ir", ir_out, 16'h0000);
    check("rst_mid_flags", alu_flags, 4'b0000);
    rst_n = 1'b1;
    idle();

    // Randomized cycles against the model
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 49) != 0);
      rf_load    = 8'($urandom);
      rf_funsel  = 2'($urandom);
      rf_rsel    = 4'($urandom);
      rf_tsel    = 4'($urandom);
      rf_o1sel   = 3'($urandom);
      rf_o2sel   = 3'($urandom);
      ir_data    = 8'($urandom);
      ir_enable  = 1'($urandom);
      ir_funsel  = 2'($urandom);
      ir_lh      = 1'($urandom);
      alu_funsel = 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
